// File: rtl/ram_clr_seq.sv
// ram_clr_seq: parametrised single-port RAM that zeroes itself after reset or on request.
// Define RAM_CLR_SEQ_REG_OUT_EN for a registered read port (1-cycle latency, old data on read-during-write).
module ram_clr_seq #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  ram_in,
  input  logic [ADDR_W-1:0] ram_add,
  input  logic              write,
  input  logic              ram_clr,
  output logic [WIDTH-1:0]  ram_out,
  output logic              ram_busy,
  output logic              ram_drop
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              in_rng, busy, last, we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  assign in_rng   = {1'b0, ram_add} < (ADDR_W+1)'(DEPTH);
  assign busy     = state_q == CLEAR;
  assign last     = cnt_q == ADDR_W'(DEPTH - 1);
  assign ram_busy = busy;
  assign ram_drop = drop_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = write && (busy || ram_clr || !in_rng);
    we      = 1'b0;
    waddr   = ram_add;
    wdata   = ram_in;
    if (ram_clr) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (busy) begin
      we      = 1'b1;
      waddr   = cnt_q;
      wdata   = '0;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? IDLE : CLEAR;
    end else begin
      we = write && in_rng;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end
`ifdef RAM_CLR_SEQ_REG_OUT_EN
  logic [WIDTH-1:0] out_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= (busy || !in_rng) ? '0 : mem_q[ram_add];
  end
  assign ram_out = out_q;
`else
  assign ram_out = (busy || !in_rng) ? '0 : mem_q[ram_add];
`endif
endmodule
